// File: rtl/axi_lite_rr_arbiter.sv
// N-master to 1-slave AXI4-Lite arbiter: round-robin grant, one outstanding transaction,
// grant held until the read or write response handshake completes.
//   state   | meaning
//   IDLE    | no grant; pick next requester after last_grant
//   RD_ADDR | AR channel of granted master forwarded to slave
//   RD_DATA | waiting for R handshake
//   WR_REQ  | AW and W forwarded independently until both complete
//   WR_RESP | waiting for B handshake
module axi_lite_rr_arbiter #(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_M-1:0]             m_arvalid,
    input  logic [NUM_M-1:0]             m_awvalid,
    input  logic [NUM_M-1:0]             m_wvalid,
    input  logic [NUM_M-1:0]             m_rready,
    input  logic [NUM_M-1:0]             m_bready,
    input  logic [NUM_M*ADDR_W-1:0]      m_araddr,
    input  logic [NUM_M*ADDR_W-1:0]      m_awaddr,
    input  logic [NUM_M*DATA_W-1:0]      m_wdata,
    input  logic [NUM_M*DATA_W/8-1:0]    m_wstrb,
    output logic [NUM_M-1:0]             m_arready,
    output logic [NUM_M-1:0]             m_awready,
    output logic [NUM_M-1:0]             m_wready,
    output logic [NUM_M-1:0]             m_rvalid,
    output logic [NUM_M-1:0]             m_bvalid,
    output logic [DATA_W-1:0]            m_rdata,
    output logic [1:0]                   m_rresp,
    output logic [1:0]                   m_bresp,
    output logic                         s_arvalid,
    output logic                         s_awvalid,
    output logic                         s_wvalid,
    output logic                         s_rready,
    output logic                         s_bready,
    output logic [ADDR_W-1:0]            s_araddr,
    output logic [ADDR_W-1:0]            s_awaddr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_wstrb,
    input  logic                         s_arready,
    input  logic                         s_awready,
    input  logic                         s_wready,
    input  logic                         s_rvalid,
    input  logic                         s_bvalid,
    input  logic [DATA_W-1:0]            s_rdata,
    input  logic [1:0]                   s_rresp,
    input  logic [1:0]                   s_bresp,
    output logic [NUM_M-1:0]             grant,
    output logic                         busy
);

    localparam int IDX_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

    state_t           state;
    logic [IDX_W-1:0] g;
    logic [IDX_W-1:0] last_grant;
    logic             aw_done;
    logic             w_done;

    logic [NUM_M-1:0] req;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] scan_idx;
    logic             pick_valid;
    logic             aw_hs;
    logic             w_hs;

    assign req     = m_arvalid | m_awvalid;
    assign aw_hs   = s_awvalid & s_awready;
    assign w_hs    = s_wvalid & s_wready;
    assign busy    = (state != IDLE);
    assign m_rdata = s_rdata;
    assign m_rresp = s_rresp;
    assign m_bresp = s_bresp;

    // Scan starts just after the last completed grant and wraps.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        scan_idx   = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            scan_idx = IDX_W'((int'(last_grant) + k) % NUM_M);
            if (!pick_valid && req[scan_idx]) begin
                pick_valid = 1'b1;
                pick       = scan_idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            g          <= '0;
            last_grant <= IDX_W'(NUM_M - 1);
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        g     <= pick;
                        state <= m_arvalid[pick] ? RD_ADDR : WR_REQ;
                    end
                end
                RD_ADDR: begin
                    if (s_arvalid && s_arready) begin
                        state <= RD_DATA;
                    end else if (!m_arvalid[g]) begin
                        // Dropped request is illegal; release the grant rather than stall.
                        last_grant <= g;
                        state      <= IDLE;
                    end
                end
                RD_DATA: begin
                    if (s_rvalid && s_rready) begin
                        last_grant <= g;
                        state      <= IDLE;
                    end
                end
                WR_REQ: begin
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= WR_RESP;
                    end else if (!aw_done && !m_awvalid[g]) begin
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        last_grant <= g;
                        state      <= IDLE;
                    end else begin
                        if (aw_hs) aw_done <= 1'b1;
                        if (w_hs)  w_done  <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (s_bvalid && s_bready) begin
                        last_grant <= g;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        m_arready = '0;
        m_awready = '0;
        m_wready  = '0;
        m_rvalid  = '0;
        m_bvalid  = '0;
        s_arvalid = 1'b0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_rready  = 1'b0;
        s_bready  = 1'b0;
        s_araddr  = '0;
        s_awaddr  = '0;
        s_wdata   = '0;
        s_wstrb   = '0;
        grant     = '0;
        case (state)
            RD_ADDR: begin
                s_arvalid    = m_arvalid[g];
                s_araddr     = m_araddr[int'(g)*ADDR_W +: ADDR_W];
                m_arready[g] = s_arready;
            end
            RD_DATA: begin
                s_rready    = m_rready[g];
                m_rvalid[g] = s_rvalid;
            end
            WR_REQ: begin
                s_awvalid    = m_awvalid[g] & ~aw_done;
                s_wvalid     = m_wvalid[g] & ~w_done;
                s_awaddr     = m_awaddr[int'(g)*ADDR_W +: ADDR_W];
                s_wdata      = m_wdata[int'(g)*DATA_W +: DATA_W];
                s_wstrb      = m_wstrb[int'(g)*STRB_W +: STRB_W];
                m_awready[g] = s_awready & ~aw_done;
                m_wready[g]  = s_wready & ~w_done;
            end
            WR_RESP: begin
                s_bready    = m_bready[g];
                m_bvalid[g] = s_bvalid;
            end
            default: ;
        endcase
        if (state != IDLE) grant[g] = 1'b1;
    end

endmodule

// File: doc/axi_lite_rr_arbiter.md
Name: axi_lite_rr_arbiter

Overview:
- Parametrised N-master to 1-slave AXI4-Lite arbiter. It replaces the fixed two-master (IFU/LSU) arbiter in the core top level.
- Round-robin fairness is used. One transaction is outstanding at a time, and the grant stays locked until the response handshake completes.
- Every master can issue both read and write transactions.
- The slave side connects to the xbar.

Parameters:
NUM_M, 2, number of masters (2..8); index 0 = IFU by convention
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width = DATA_W/8

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
m_arvalid/m_awvalid/m_wvalid/m_rready/m_bready  in  NUM_M each  per-master request/ready bits
m_araddr/m_awaddr  in  NUM_M*ADDR_W  packed; master i at [i*ADDR_W +: ADDR_W]
m_wdata  in  NUM_M*DATA_W  packed write data
m_wstrb  in  NUM_M*DATA_W/8  packed strobes
m_arready/m_awready/m_wready/m_rvalid/m_bvalid  out  NUM_M each  per-master handshake bits
m_rdata  out  DATA_W  read data, broadcast to all masters
m_rresp/m_bresp  out  2  responses, broadcast to all masters
s_arvalid/s_awvalid/s_wvalid/s_rready/s_bready  out  1  slave-side control
s_araddr/s_awaddr  out  ADDR_W  addresses of the granted master
s_wdata  out  DATA_W  write data of the granted master
s_wstrb  out  DATA_W/8  strobes of the granted master
s_arready/s_awready/s_wready/s_rvalid/s_bvalid  in  1  slave-side handshake
s_rdata  in  DATA_W  read data from slave
s_rresp/s_bresp  in  2  responses from slave
grant  out  NUM_M  one-hot granted master, 0 when idle
busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. Register the state, the grant index g, last_grant, aw_done and w_done.
- Reset values:
  - state=IDLE, last_grant=NUM_M-1 (master 0 wins first), aw_done=w_done=0.
  - All m_* ready/valid outputs = 0, all s_* valid/ready outputs = 0, grant=0, busy=0.
- Request bit: req[i] = m_arvalid[i] | m_awvalid[i].
- Arbitration in IDLE:
  - Pick the first i with req[i], scanning last_grant+1 upward and wrapping modulo NUM_M.
  - Register the winner as g. Next state is RD_ADDR if m_arvalid[g], else WR_REQ. A read beats a write from the same master.
  - The arbitration cycle drives no handshakes. Request at cycle 0 gives the s_* valid in cycle 1.
- RD_ADDR:
  - s_arvalid=m_arvalid[g], s_araddr=addr of g, m_arready[g]=s_arready.
  - On s_arvalid&s_arready go to RD_DATA.
- RD_DATA:
  - s_rready=m_rready[g], m_rvalid[g]=s_rvalid.
  - On s_rvalid&s_rready: last_grant<=g, go to IDLE.
- WR_REQ:
  - s_awvalid=m_awvalid[g]&~aw_done and s_wvalid=m_wvalid[g]&~w_done. The AW and W channels are independent and may complete in the same cycle or either order.
  - m_awready[g]=s_awready&~aw_done and m_wready[g]=s_wready&~w_done.
  - Set aw_done on the AW handshake and w_done on the W handshake.
  - When both are done, counting the current cycle's handshakes: go to WR_RESP and clear both flags.
- WR_RESP:
  - s_bready=m_bready[g], m_bvalid[g]=s_bvalid.
  - On handshake: last_grant<=g, go to IDLE.
- Non-granted masters see all ready/valid bits = 0 in every state.
- m_rdata, m_rresp and m_bresp are combinational pass-throughs of the s_* signals. Only the per-master valid bits are gated.
- s_* address/data outputs are 0 when not in the matching state.
- Boundary rules:
  - A master deasserting arvalid/awvalid mid-grant is illegal AXI and undefined. The implementation must not hang in IDLE.
  - Equal-priority simultaneous requests are resolved purely by last_grant.
  - No new grant is issued while busy. A back-to-back request is re-arbitrated after exactly one IDLE cycle.
  - Reset asserted mid-transaction abandons the transaction: next cycle is IDLE and all valids are low.
- Error responses (SLVERR/DECERR) are forwarded unchanged and do not alter the FSM.

Test Plan:
- NUM_M=3; masters 0, 1 and 2 all assert arvalid at cycle 0; slave has 1-cycle ready → grants in order 0,1,2; grant=001,010,100; each read returns its own address as rdata.
- Master 1 issues a write (awaddr=0x8000_0010, wdata=0xDEADBEEF, wstrb=0xF) with W arriving 3 cycles before AW → s_awvalid/s_wvalid each asserted once, m_bvalid[1] pulses with bresp=00, master 0 sees no handshake.
- Master 0 requests read and write simultaneously → read completes first, write granted after one IDLE cycle (round-robin skips to master 0 again only if no others request).
- Slave holds rvalid for 10 cycles with rready=0 from master 2 → grant stays 100, busy=1, no other master gets arready.
- Slave returns rresp=2'b10 → m_rresp=10 and m_rvalid[g]=1, then FSM back to IDLE.
- Reset asserted in RD_DATA → next cycle busy=0, grant=0, s_rready=0; first post-reset grant goes to master 0.
